uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; successor to the fixed 8N2, divide-by-8 sender.
- Bit period, data width, parity mode and stop-bit count are set by parameters.
- `char` is latched when the request is accepted, so the bus may change mid-frame.
- Four-phase Req/Ack handshake to the upstream producer; the serial line is driven toward the host.

Parameters:
- CLKS_PER_BIT, 8: clocks per serial bit period; legal range 2..65535.
- DATA_BITS, 8: data bits per frame, sent LSB first; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even; 3 is illegal.
- STOP_BITS, 2: stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- Req  in  1  producer request; level, four-phase.
- char  in  DATA_BITS  data to send; sampled only on the acceptance cycle.
- RxD  out  1  serial line; idle high; registered.
- Ack  out  1  frame-done acknowledge; registered.
- busy  out  1  high from the acceptance cycle until return to IDLE; registered.

Behaviour:
- Reset: clr=1 at a clock edge gives RxD=1, Ack=0, busy=0, state=IDLE, all counters 0, shift register 0. This holds even mid-frame; the frame is truncated with no glitch low.
- States: IDLE, START, DATA, PAR, STOP, ACK.
- IDLE
  - Req is sampled every clock, not only on bit ticks.
  - At edge E with Req=1: latch char into the shift register, go to START, set busy=1, clear the baud counter.
  - From E+1, RxD=0 for exactly CLKS_PER_BIT clocks.
- Baud counter
  - Width clog2(CLKS_PER_BIT).
  - Bit tick when the count equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every non-IDLE/ACK state lasts exactly CLKS_PER_BIT clocks per bit.
- DATA
  - DATA_BITS periods; RxD = shift register bit 0, shifting right on each tick.
  - Bit index counter width clog2(DATA_BITS+1).
- PAR
  - Present only if PARITY != 0; lasts one period.
  - Even: RxD = XOR of the latched data. Odd: RxD = its inverse.
  - Parity is computed from the latched value, not the live char.
- STOP: STOP_BITS periods with RxD=1.
- Frame length: F = CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) clocks, from E+1 to the end of the last stop bit.
- ACK
  - Entered at E+F+1; Ack=1 is registered on that edge, RxD=1.
  - Ack stays high while Req=1.
  - First edge sampling Req=0 in ACK: Ack=0, busy=0, state=IDLE on the following cycle.
  - If Req is already low on entry, Ack is high for exactly one cycle.
- Req dropping during START/DATA/PAR/STOP: ignored; the frame completes and Ack is still raised.
- Req held high through ACK and back to IDLE cannot occur; a new frame requires Req to be seen low first.
- Minimum gap between frames: the RxD idle-high time is at least 2 clocks (ACK entry plus the Req-low sample).
- char changing after E: no effect on the frame in progress.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port `brk` (1 bit).
  - In IDLE with brk=1: RxD=0 from the next cycle for as long as brk stays high; Req is not accepted; busy=1, Ack=0.
  - brk falling: RxD=1 on the next cycle, then at least CLKS_PER_BIT idle-high clocks (the mark-after-break) before a Req can be accepted.
  - brk asserted during a frame or in ACK: ignored until IDLE is re-entered.
- Undefined: no `brk` port and no break logic; behaviour exactly as above.

Test Plan:
- Defaults (8 clk/bit, 8 data, no parity, 2 stop), char=0xA5, Req held until Ack, then dropped.
  - RxD per 8-clock period: 0,1,0,1,0,0,1,0,1,1,1.
  - Ack rises 89 clocks after the acceptance edge (88-clock frame); Ack and busy fall one cycle after Req=0.
- PARITY=2, char=0xA5: parity bit 0. PARITY=1, char=0x07: parity bit 0. PARITY=1, char=0x00: parity bit 1. Each frame is 96 clocks with STOP_BITS=2.
- char changed 0xA5 -> 0xFF at E+3: the transmitted data bits still match 0xA5.
- Req dropped at E+20: the frame completes; Ack is high for one cycle only.
- clr pulsed at E+40 (mid-data): RxD=1, Ack=0, busy=0 the next cycle; a new Req 5 clocks later starts a clean start bit.
- CLKS_PER_BIT=3, DATA_BITS=5, STOP_BITS=1, char=0x13: frame is 21 clocks, RxD per 3-clock period 0,1,1,0,0,1,1. With UART_TX_BREAK_EN, brk held 30 clocks: RxD low for 30 clocks, and a Req raised right after brk falls is accepted 3 clocks later.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake and serial-line bundle for uart_tx_frame; brk exists only with UART_TX_BREAK_EN.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 Req;
   logic [DATA_BITS-1:0] char;
   logic                 RxD;
   logic                 Ack;
   logic                 busy;
`ifdef UART_TX_BREAK_EN
   logic                 brk;

   modport master (output Req, char, brk, input RxD, Ack, busy);
   modport slave  (input Req, char, brk, output RxD, Ack, busy);
`else
   modport master (output Req, char, input RxD, Ack, busy);
   modport slave  (input Req, char, output RxD, Ack, busy);
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART sender with four-phase Req/Ack; UART_TX_BREAK_EN adds a brk input for line breaks.
// Latency: start bit appears one clock after Req is accepted; Ack rises one clock after the last stop bit.
// Backpressure: busy holds off new frames; Ack stays high until the producer drops Req.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 2
) (
   input  logic           clk,
   input  logic           clr,
   uart_tx_frame_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, ACK, BRK, MAB} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, ACK} state_t;
`endif

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [BW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] sh, sh_nxt;
   logic                 par, par_nxt;
   logic                 rxd_q, rxd_nxt;
   logic                 ack_q, ack_nxt;
   logic                 busy_q, busy_nxt;
   logic                 tick, timed, take;

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         sh     <= '0;
         par    <= 1'b0;
         rxd_q  <= 1'b1;
         ack_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         sh     <= sh_nxt;
         par    <= par_nxt;
         rxd_q  <= rxd_nxt;
         ack_q  <= ack_nxt;
         busy_q <= busy_nxt;
      end
   end

   // RxD is registered from the current state, so the line lags the state by one clock.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      sh_nxt    = sh;
      par_nxt   = par;
      rxd_nxt   = 1'b1;
      ack_nxt   = 1'b0;
      busy_nxt  = busy_q;
      tick      = (cnt == CNT_LAST);
      timed     = 1'b0;
      take      = 1'b0;

      case (state)
         IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (bus.brk) begin
               state_nxt = BRK;
               rxd_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end else begin
               take = bus.Req;
            end
`else
            take = bus.Req;
`endif
         end
         START: begin
            timed   = 1'b1;
            rxd_nxt = 1'b0;
            if (tick) begin
               idx_nxt   = '0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            timed   = 1'b1;
            rxd_nxt = sh[0];
            if (tick) begin
               sh_nxt  = sh >> 1;
               idx_nxt = idx + 1'b1;
               if (idx == DATA_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = (PARITY != 0) ? PAR : STOP;
               end
            end
         end
         PAR: begin
            timed   = 1'b1;
            rxd_nxt = par;
            if (tick) begin
               idx_nxt   = '0;
               state_nxt = STOP;
            end
         end
         STOP: begin
            timed = 1'b1;
            if (tick) begin
               idx_nxt = idx + 1'b1;
               if (idx == STOP_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = ACK;
               end
            end
         end
         ACK: begin
            ack_nxt = 1'b1;
            // Release only once Ack is visible and the producer has let go of Req.
            if (ack_q && !bus.Req) begin
               ack_nxt   = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
`ifdef UART_TX_BREAK_EN
         BRK: begin
            busy_nxt = 1'b1;
            if (bus.brk) begin
               rxd_nxt = 1'b0;
            end else begin
               cnt_nxt   = '0;
               state_nxt = MAB;
            end
         end
         MAB: begin
            timed = 1'b1;
            if (tick) begin
               if (bus.Req) begin
                  take = 1'b1;
               end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      if (timed) begin
         cnt_nxt = tick ? '0 : cnt + 1'b1;
      end

      if (take) begin
         state_nxt = START;
         sh_nxt    = bus.char;
         par_nxt   = (PARITY == 1) ? ~^bus.char : ^bus.char;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         busy_nxt  = 1'b1;
      end
   end

   assign bus.RxD  = rxd_q;
   assign bus.Ack  = ack_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations run against a frame-level reference model,
// checked every cycle, plus literal bit/timing expectations for the documented frames.
module tb_uart_tx_frame;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] clr_v;
   logic [3:0] req;
   logic [8:0] ch [4];
`ifdef UART_TX_BREAK_EN
   logic [3:0] brk;
`endif
   wire  [3:0] d_rxd, d_ack, d_busy;

   uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
   uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
   uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
   uart_tx_frame_if #(.DATA_BITS(5)) if3 ();

   assign if0.Req = req[0];  assign if0.char = ch[0][7:0];
   assign if1.Req = req[1];  assign if1.char = ch[1][7:0];
   assign if2.Req = req[2];  assign if2.char = ch[2][7:0];
   assign if3.Req = req[3];  assign if3.char = ch[3][4:0];
`ifdef UART_TX_BREAK_EN
   assign if0.brk = brk[0];  assign if1.brk = brk[1];
   assign if2.brk = brk[2];  assign if3.brk = brk[3];
`endif
   assign d_rxd  = {if3.RxD,  if2.RxD,  if1.RxD,  if0.RxD};
   assign d_ack  = {if3.Ack,  if2.Ack,  if1.Ack,  if0.Ack};
   assign d_busy = {if3.busy, if2.busy, if1.busy, if0.busy};

   uart_tx_frame #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
      u0 (.clk(clk), .clr(clr_v[0]), .bus(if0));
   uart_tx_frame #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
      u1 (.clk(clk), .clr(clr_v[1]), .bus(if1));
   uart_tx_frame #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
      u2 (.clk(clk), .clr(clr_v[2]), .bus(if2));
   uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1))
      u3 (.clk(clk), .clr(clr_v[3]), .bus(if3));

   int cpb   [4] = '{8, 8, 8, 3};
   int dbits [4] = '{8, 8, 8, 5};
   int pmode [4] = '{0, 2, 1, 0};
   int sbits [4] = '{2, 2, 2, 1};

   // Model: mode 0 idle, 1 frame, 2 ack, 3 break, 4 mark-after-break.
   int          cyc = 0;
   int          mode [4], tt [4], mm [4], flen [4], e_cyc [4], ack_at [4], ack_cnt [4];
   logic [15:0] fbits [4];
   logic        exp_rxd [4], exp_ack [4], exp_busy [4];
   logic        cap [4][128];
   int          n_cmp = 0, n_bad = 0;
   bit          chk_en = 1'b0;
   int          lit_a [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
   int          lit_3 [7]  = '{0, 1, 1, 0, 0, 1, 1};

   function automatic logic [15:0] build(input int i, input logic [8:0] c);
      logic [15:0] v;
      logic        p;
      v    = '1;
      v[0] = 1'b0;
      p    = 1'b0;
      for (int j = 0; j < dbits[i]; j++) begin
         v[1+j] = c[j];
         p      = p ^ c[j];
      end
      if (pmode[i] == 2) v[1+dbits[i]] = p;
      if (pmode[i] == 1) v[1+dbits[i]] = ~p;
      return v;
   endfunction

   task automatic m_accept(input int i);
      fbits[i]    = build(i, ch[i]);
      flen[i]     = 1 + dbits[i] + ((pmode[i] != 0) ? 1 : 0) + sbits[i];
      mode[i]     = 1;
      tt[i]       = 0;
      exp_busy[i] = 1'b1;
      exp_rxd[i]  = 1'b1;
      e_cyc[i]    = cyc;
   endtask

   task automatic model_update();
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (clr_v[i]) begin
            mode[i] = 0; exp_rxd[i] = 1'b1; exp_ack[i] = 1'b0; exp_busy[i] = 1'b0;
         end else begin
            case (mode[i])
               0: begin
`ifdef UART_TX_BREAK_EN
                  if (brk[i]) begin
                     mode[i] = 3; exp_rxd[i] = 1'b0; exp_busy[i] = 1'b1;
                  end else
`endif
                  if (req[i]) m_accept(i);
               end
               1: begin
                  tt[i]++;
                  if (tt[i] <= flen[i] * cpb[i]) exp_rxd[i] = fbits[i][(tt[i] - 1) / cpb[i]];
                  else begin
                     mode[i] = 2; exp_ack[i] = 1'b1; exp_rxd[i] = 1'b1;
                  end
               end
               2: if (!req[i]) begin
                  mode[i] = 0; exp_ack[i] = 1'b0; exp_busy[i] = 1'b0;
               end
`ifdef UART_TX_BREAK_EN
               3: if (!brk[i]) begin
                  mode[i] = 4; mm[i] = 0; exp_rxd[i] = 1'b1;
               end
               4: begin
                  mm[i]++;
                  if (mm[i] == cpb[i]) begin
                     if (req[i]) m_accept(i);
                     else begin
                        mode[i] = 0; exp_busy[i] = 1'b0;
                     end
                  end
               end
`endif
               default: mode[i] = 0;
            endcase
         end
      end
   endtask

   task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s[%0d] cyc %0d: got %0h want %0h", nm, idx, cyc, got, want);
      end
   endtask

   task automatic compare();
      int d;
      if (!chk_en) return;
      for (int i = 0; i < 4; i++) begin
         check("rxd",  i, 32'(d_rxd[i]),  32'(exp_rxd[i]));
         check("ack",  i, 32'(d_ack[i]),  32'(exp_ack[i]));
         check("busy", i, 32'(d_busy[i]), 32'(exp_busy[i]));
         d = cyc - e_cyc[i];
         if (d == 0) begin
            ack_at[i] = -1; ack_cnt[i] = 0;
         end
         if (d >= 0 && d < 128) cap[i][d] = d_rxd[i];
         if (d_ack[i] === 1'b1) begin
            ack_cnt[i]++;
            if (ack_at[i] < 0) ack_at[i] = d;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic send(input int i, input logic [8:0] c, input int drop_after,
                       input int chg_at, input logic [8:0] chg_val);
      int k;
      ch[i]  = c;
      req[i] = 1'b1;
      k = 0;
      do begin step(); k++; end while (mode[i] != 1 && k < 50);
      if (mode[i] != 1) begin
         check("accept_timeout", i, 32'(mode[i]), 32'd1);
         req[i] = 1'b0;
         return;
      end
      k = 0;
      while (k < 400) begin
         if (cyc - e_cyc[i] == chg_at) ch[i] = chg_val;
         if (drop_after >= 0 ? (cyc - e_cyc[i] >= drop_after) : (d_ack[i] === 1'b1)) break;
         step();
         k++;
      end
      req[i] = 1'b0;
      if (k >= 400) check("ack_timeout", i, 32'(d_ack[i]), 32'd1);
      k = 0;
      while (mode[i] != 0 && k < 400) begin step(); k++; end
      if (mode[i] != 0) check("idle_timeout", i, 32'(mode[i]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, lows, fall, ci, drop, chg;
      clr_v = '1;
      req   = '0;
      for (int i = 0; i < 4; i++) begin
         ch[i] = '0; mode[i] = 0; e_cyc[i] = 0; ack_at[i] = -1; ack_cnt[i] = 0;
         exp_rxd[i] = 1'b1; exp_ack[i] = 1'b0; exp_busy[i] = 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      brk = '0;
`endif
      repeat (3) step();
      chk_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rst_rxd",  i, 32'(d_rxd[i]),  32'd1);
         check("rst_ack",  i, 32'(d_ack[i]),  32'd0);
         check("rst_busy", i, 32'(d_busy[i]), 32'd0);
      end
      clr_v = '0;
      step();

      // Default 8N2 frame of 0xA5.
      send(0, 9'h0A5, -1, -1, 9'h0);
      for (int b = 0; b < 11; b++) check("a5_bit", b, 32'(cap[0][1 + 8*b + 4]), 32'(lit_a[b]));
      check("a5_ack_at", 0, 32'(ack_at[0]), 32'd89);

      // Parity bits.
      send(1, 9'h0A5, -1, -1, 9'h0);
      check("even_a5_par", 1, 32'(cap[1][1 + 8*9 + 4]), 32'd0);
      check("par_ack_at", 1, 32'(ack_at[1]), 32'd97);
      send(2, 9'h007, -1, -1, 9'h0);
      check("odd_07_par", 2, 32'(cap[2][1 + 8*9 + 4]), 32'd0);
      send(2, 9'h000, -1, -1, 9'h0);
      check("odd_00_par", 2, 32'(cap[2][1 + 8*9 + 4]), 32'd1);

      // char changes after acceptance.
      send(0, 9'h0A5, -1, 3, 9'h0FF);
      for (int b = 1; b < 9; b++) check("latched_bit", b, 32'(cap[0][1 + 8*b + 4]), 32'(lit_a[b]));

      // Req dropped mid-frame.
      send(0, 9'h0A5, 20, -1, 9'h0);
      check("early_drop_ack_len", 0, 32'(ack_cnt[0]), 32'd1);

      // clr mid-data, then a fresh frame.
      ch[0] = 9'h0A5; req[0] = 1'b1;
      step();
      repeat (39) step();
      clr_v[0] = 1'b1; req[0] = 1'b0;
      step();
      check("clr_rxd",  0, 32'(d_rxd[0]),  32'd1);
      check("clr_ack",  0, 32'(d_ack[0]),  32'd0);
      check("clr_busy", 0, 32'(d_busy[0]), 32'd0);
      clr_v[0] = 1'b0;
      repeat (4) step();
      send(0, 9'h0C3, -1, -1, 9'h0);
      check("restart_start", 0, 32'(cap[0][4]), 32'd0);
      check("restart_ack_at", 0, 32'(ack_at[0]), 32'd89);

      // Short configuration: 3 clk/bit, 5N1.
      send(3, 9'h013, -1, -1, 9'h0);
      for (int b = 0; b < 7; b++) check("c3_bit", b, 32'(cap[3][1 + 3*b + 1]), 32'(lit_3[b]));
      check("c3_ack_at", 3, 32'(ack_at[3]), 32'd22);

`ifdef UART_TX_BREAK_EN
      brk[3] = 1'b1;
      lows = 0;
      repeat (30) begin
         step();
         if (d_rxd[3] === 1'b0) lows++;
      end
      brk[3] = 1'b0; ch[3] = 9'h00A; req[3] = 1'b1;
      fall = cyc + 1;
      k = 0;
      do begin step(); k++; end while (mode[3] != 1 && k < 20);
      check("brk_low_len", 3, 32'(lows), 32'd30);
      check("mab_accept", 3, 32'(e_cyc[3] - fall), 32'd3);
      k = 0;
      while (d_ack[3] !== 1'b1 && k < 100) begin step(); k++; end
      req[3] = 1'b0;
      k = 0;
      while (mode[3] != 0 && k < 100) begin step(); k++; end
      check("brk_frame_idle", 3, 32'(mode[3]), 32'd0);
`endif

      // Randomised frames across all configurations.
      for (int n = 0; n < 40; n++) begin
         ci   = $urandom_range(0, 3);
         drop = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 110));
         chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
         send(ci, 9'($urandom_range(0, 511)), drop, chg, 9'($urandom_range(0, 511)));
         repeat ($urandom_range(0, 4)) step();
      end

      repeat (5) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
